// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: buffers words from a valid/ready port in a FIFO
// and shifts each word out one bit at a time at a programmable bit period.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   div                 bit period minus 1, in clk cycles
//   msb_first           bit order, latched at each word load
//   s_valid/s_ready     upstream handshake, s_data is the word
//   ser_out/ser_valid   registered serial bit and its qualifier
//   busy, level         activity flag and FIFO occupancy
module serial_bit_feeder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int DIV_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DIV_W-1:0]           div,
  input  logic                       msb_first,
  input  logic                       s_valid,
  input  logic [DATA_W-1:0]          s_data,
  output logic                       s_ready,
  output logic                       ser_out,
  output logic                       ser_valid,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [DATA_W-1:0]  shreg;
  logic               msb_l;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DIV_W-1:0]   tick_cnt;
  logic [DATA_W-1:0]  head;
  logic               push;
  logic               pop;
  logic               last;

  assign head    = mem[rd_ptr];
  assign s_ready = (level != LVL_W'(DEPTH));
  assign push    = s_valid && s_ready;
  // last cycle of the last bit; both counters rest at 0 in IDLE as well
  assign last    = (tick_cnt == '0) && (bit_cnt == '0);
  assign pop     = (level != '0) && ((state == IDLE) || last);
  assign busy    = (state == SHIFT) || (level != '0);

  // storage is not reset; occupancy is tracked by level alone
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      shreg     <= '0;
      msb_l     <= 1'b0;
      bit_cnt   <= '0;
      tick_cnt  <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (!push && pop) level <= level - LVL_W'(1);

      if (pop) begin
        state     <= SHIFT;
        shreg     <= head;
        msb_l     <= msb_first;
        ser_out   <= msb_first ? head[DATA_W-1] : head[0];
        ser_valid <= 1'b1;
        bit_cnt   <= CNT_W'(DATA_W-1);
        tick_cnt  <= div;
      end else if (state == SHIFT) begin
        if (tick_cnt != '0) begin
          tick_cnt <= tick_cnt - 1'b1;
        end else if (bit_cnt != '0) begin
          // shreg keeps the current bit at its output end
          if (msb_l) begin
            shreg   <= {shreg[DATA_W-2:0], 1'b0};
            ser_out <= shreg[DATA_W-2];
          end else begin
            shreg   <= {1'b0, shreg[DATA_W-1:1]};
            ser_out <= shreg[1];
          end
          bit_cnt  <= bit_cnt - 1'b1;
          tick_cnt <= div;
        end else begin
          state     <= IDLE;
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_serial_bit_feeder;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int DIV_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [DIV_W-1:0]  div;
  logic              msb_first;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              ser_out;
  logic              ser_valid;
  logic              busy;
  logic [2:0]        level;

  serial_bit_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .div(div), .msb_first(msb_first),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: word queue, bits left in the current word, and
  // cycles left on the bit being shown.
  logic [DATA_W-1:0] mq [$];
  bit                mbits [$];
  bit                mact;
  bit                mcur;
  int                mleft;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mbits.delete();
      mact  = 1'b0;
      mcur  = 1'b0;
      mleft = 0;
    end else begin
      logic [DATA_W-1:0] w;
      bit do_push;
      do_push = s_valid && (mq.size() < DEPTH);
      if (mact && mleft > 1) begin
        mleft--;
      end else if (mact && mbits.size() != 0) begin
        mcur  = mbits.pop_front();
        mleft = int'(div) + 1;
      end else if (mq.size() != 0) begin
        w = mq.pop_front();
        mbits.delete();
        for (int i = 0; i < DATA_W; i++)
          mbits.push_back(msb_first ? w[DATA_W-1-i] : w[i]);
        mcur  = mbits.pop_front();
        mleft = int'(div) + 1;
        mact  = 1'b1;
      end else begin
        mact = 1'b0;
      end
      if (do_push) mq.push_back(s_data);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_ser_valid", 32'(ser_valid), 32'(mact));
      chk("m_ser_out", 32'(ser_out), 32'(mact && mcur));
      chk("m_level", 32'(level), 32'(mq.size()));
      chk("m_s_ready", 32'(s_ready), 32'(mq.size() < DEPTH));
      chk("m_busy", 32'(busy), 32'(mact || mq.size() != 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] w4 [6];
  logic [7:0]        e1;
  logic [15:0]       e3;
  logic [12:0]       e6;
  int                k;
  int                cyc;
  bit                will;

  initial begin
    rst       = 1'b1;
    div       = '0;
    msb_first = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    #12;
    chk("rst_ser_out", 32'(ser_out), 0);
    chk("rst_ser_valid", 32'(ser_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_s_ready", 32'(s_ready), 1);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    cmp_en = 1'b1;
    tick();

    // 1: 0xB3, MSB first, one bit per clock
    e1 = 8'b1011_0011;
    div = 0; msb_first = 1;
    s_valid = 1; s_data = 8'hB3;
    tick();
    s_valid = 0;
    chk("t1_lat0", 32'(ser_valid), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t1_bit", 32'(ser_out), 32'(e1[7-i]));
      chk("t1_valid", 32'(ser_valid), 1);
    end
    tick();
    chk("t1_end_valid", 32'(ser_valid), 0);
    chk("t1_end_out", 32'(ser_out), 0);
    chk("t1_end_busy", 32'(busy), 0);
    tick();

    // 2: 0x01, LSB first, 3 cycles per bit
    div = 2; msb_first = 0;
    s_valid = 1; s_data = 8'h01;
    tick();
    s_valid = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      chk("t2_bit", 32'(ser_out), 32'(i < 3));
      chk("t2_valid", 32'(ser_valid), 1);
    end
    tick();
    chk("t2_end_valid", 32'(ser_valid), 0);
    tick();

    // 3: back-to-back words stream with no gap
    e3 = 16'hE0FF;
    div = 0; msb_first = 1;
    s_valid = 1; s_data = 8'hE0;
    tick();
    s_data = 8'hFF;
    tick();
    s_valid = 0;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) tick();
      chk("t3_bit", 32'(ser_out), 32'(e3[15-i]));
      chk("t3_valid", 32'(ser_valid), 1);
    end
    tick();
    chk("t3_end_valid", 32'(ser_valid), 0);
    tick();

    // 4: backpressure with six words, div=3
    w4[0] = 8'h11; w4[1] = 8'h22; w4[2] = 8'h3C;
    w4[3] = 8'h4D; w4[4] = 8'h5A; w4[5] = 8'h69;
    div = 3; msb_first = 1;
    k = 0; cyc = 0;
    s_valid = 1;
    while (k < 6 && cyc < 300) begin
      s_data = w4[k];
      will = (mq.size() < DEPTH);
      tick();
      cyc++;
      if (will) begin
        k++;
        if (k == 5) begin
          chk("t4_full_level", 32'(level), 4);
          chk("t4_full_ready", 32'(s_ready), 0);
        end
      end
    end
    s_valid = 0;
    chk("t4_accepts", 32'(k), 6);
    chk("t4_sixth_cycle", 32'(cyc), 35);
    repeat (6 * 32 + 5) tick();
    chk("t4_drained_busy", 32'(busy), 0);

    // 5: asynchronous reset mid-word with two words queued
    div = 0; msb_first = 1;
    s_valid = 1; s_data = 8'hFF;
    repeat (3) tick();
    s_valid = 0;
    repeat (3) tick();
    chk("t5_pre_level", 32'(level), 2);
    chk("t5_pre_out", 32'(ser_out), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_out", 32'(ser_out), 0);
    chk("t5_rst_valid", 32'(ser_valid), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_level", 32'(level), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_post_out", 32'(ser_out), 0);
    end

    // 6: div changes from 0 to 1 during bit 2 of 0xAA
    e6 = 13'b1010011001100;
    div = 0; msb_first = 1;
    s_valid = 1; s_data = 8'hAA;
    tick();
    s_valid = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i == 2) div = 1;
      chk("t6_bit", 32'(ser_out), 32'(e6[12-i]));
      chk("t6_valid", 32'(ser_valid), 1);
    end
    tick();
    chk("t6_end_valid", 32'(ser_valid), 0);
    tick();

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
